// File: rtl/comm_mem_pkg.sv
// Shared constants and round-robin helper for the communication memory arbiter.
package comm_mem_pkg;

    localparam int unsigned COMM_MEM_DEPTH  = 25600;
    localparam int unsigned COMM_MEM_ADDR_W = 15;
    localparam int unsigned COMM_MEM_DATA_W = 32;
    localparam int unsigned COMM_MEM_BE_W   = 4;
    localparam int unsigned COMM_MEM_MAX_REQ = 4;

    // First active requester scanning last+1, last+2, ... (mod num_req); last itself is checked last.
    function automatic logic [1:0] next_rr(input logic [3:0] req_vec,
                                           input logic [1:0] last,
                                           input int unsigned num_req);
        logic [1:0]  win;
        int unsigned idx;
        win = last;
        for (int k = int'(num_req); k >= 1; k--) begin
            idx = (32'(last) + 32'(k)) % num_req;
            if (req_vec[idx[1:0]]) win = idx[1:0];
        end
        return win;
    endfunction

endpackage

// File: rtl/comm_mem_arbiter_rr_sel.sv
// Combinational round-robin selector with a bounded hold window for the current owner.
module comm_mem_rr_sel
    import comm_mem_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic [NUM_REQ-1:0]                              active,
    input  logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0]  last_grant,
    input  logic [(MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1)-1:0] hold_cnt,
    input  logic                                            streak,
    output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0]  winner_c,
    output logic                                            any_grant_c
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [NUM_REQ-1:0] others;
    logic               keep;

    // The owner may only keep the grant while its run of accesses is unbroken.
    always_comb begin
        others      = active & ~(NUM_REQ'(1) << last_grant);
        keep        = streak && active[last_grant] &&
                      ((hold_cnt < HOLD_W'(MAX_HOLD - 1)) || (others == '0));
        winner_c    = keep ? last_grant
                           : IDX_W'(next_rr(4'(active), 2'(last_grant), NUM_REQ));
        any_grant_c = |active;
    end

endmodule

// File: rtl/comm_mem_arbiter.sv
// Shares the single-port communication RAM between NUM_REQ Avalon-MM requesters.
module comm_mem_arbiter
    import comm_mem_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned ADDR_W   = COMM_MEM_ADDR_W,
    parameter int unsigned DEPTH    = COMM_MEM_DEPTH,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0]            req_address,
    input  logic [NUM_REQ*COMM_MEM_BE_W-1:0]     req_byteenable,
    input  logic [NUM_REQ-1:0]                   req_read,
    input  logic [NUM_REQ-1:0]                   req_write,
    input  logic [NUM_REQ*COMM_MEM_DATA_W-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]                   req_waitrequest,
    output logic [COMM_MEM_DATA_W-1:0]           req_readdata,
    output logic [NUM_REQ-1:0]                   req_readdatavalid,
    output logic                                 oor_error,
    output logic [ADDR_W-1:0]                    mem_address,
    output logic [COMM_MEM_BE_W-1:0]             mem_byteenable,
    output logic                                 mem_chipselect,
    output logic                                 mem_write,
    output logic [COMM_MEM_DATA_W-1:0]           mem_writedata,
    output logic                                 mem_clken,
    input  logic [COMM_MEM_DATA_W-1:0]           mem_readdata
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned BE_W   = COMM_MEM_BE_W;
    localparam int unsigned DATA_W = COMM_MEM_DATA_W;

    logic [NUM_REQ-1:0] active;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   rd_owner;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               streak;
    logic               any_grant;
    logic               issue;
    logic               win_read;
    logic               oor;
    logic               rd_pending;
    logic               rd_oor;
    logic [ADDR_W-1:0]  addr_sel;
    int unsigned        wi;

    assign active = req_read | req_write;
    assign issue  = any_grant & reset_n;

    comm_mem_rr_sel #(
        .NUM_REQ  (NUM_REQ),
        .MAX_HOLD (MAX_HOLD)
    ) u_rr_sel (
        .active      (active),
        .last_grant  (last_grant),
        .hold_cnt    (hold_cnt),
        .streak      (streak),
        .winner_c    (winner),
        .any_grant_c (any_grant)
    );

    // Winner mux, range check and RAM drive; a write from the winner suppresses its read.
    always_comb begin
        req_waitrequest = '1;
        addr_sel        = '0;
        mem_address     = '0;
        mem_byteenable  = '0;
        mem_writedata   = '0;
        mem_chipselect  = 1'b0;
        mem_write       = 1'b0;
        oor_error       = 1'b0;
        win_read        = 1'b0;
        oor             = 1'b0;
        wi              = 32'(winner);
        if (issue) begin
            req_waitrequest[winner] = 1'b0;
            addr_sel       = req_address[wi*ADDR_W +: ADDR_W];
            oor            = 32'(addr_sel) >= DEPTH;
            mem_address    = addr_sel;
            mem_byteenable = req_byteenable[wi*BE_W +: BE_W];
            mem_writedata  = req_writedata[wi*DATA_W +: DATA_W];
            mem_chipselect = ~oor;
            mem_write      = req_write[winner];
            win_read       = req_read[winner] & ~req_write[winner];
            oor_error      = oor;
        end
    end

    // Arbitration history and the one-deep read-return pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
            hold_cnt   <= '0;
            streak     <= 1'b0;
            rd_pending <= 1'b0;
            rd_owner   <= '0;
            rd_oor     <= 1'b0;
        end else begin
            rd_pending <= win_read;
            if (win_read) begin
                rd_owner <= winner;
                rd_oor   <= oor;
            end
            if (issue) begin
                if (streak && (winner == last_grant)) begin
                    if (hold_cnt != HOLD_W'(MAX_HOLD - 1)) hold_cnt <= hold_cnt + HOLD_W'(1);
                end else begin
                    hold_cnt <= '0;
                end
                last_grant <= winner;
                streak     <= 1'b1;
            end else begin
                hold_cnt <= '0;
                streak   <= 1'b0;
            end
        end
    end

    assign req_readdatavalid = rd_pending ? (NUM_REQ'(1) << rd_owner) : '0;
    assign req_readdata      = (rd_pending && !rd_oor) ? mem_readdata : '0;
    assign mem_clken         = 1'b1;

`ifndef SYNTHESIS
    // A simultaneous read and write from the winner loses the read.
    a_rd_wr_same: assert property (@(posedge clk) disable iff (!reset_n)
        !(issue && req_read[winner] && req_write[winner]))
        else $warning("comm_mem_arbiter: read dropped, write+read from requester %0d", winner);
`endif

endmodule

// File: tb/tb_comm_mem_arbiter.sv
// Directed bench for comm_mem_arbiter with a behavioural single-port RAM.
module tb_comm_mem_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 15;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR*AW-1:0]  req_address;
    logic [NR*4-1:0]   req_byteenable;
    logic [NR-1:0]     req_read;
    logic [NR-1:0]     req_write;
    logic [NR*32-1:0]  req_writedata;
    logic [NR-1:0]     req_waitrequest;
    logic [31:0]       req_readdata;
    logic [NR-1:0]     req_readdatavalid;
    logic              oor_error;
    logic [AW-1:0]     mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    int n_chk  = 0;
    int n_fail = 0;

    comm_mem_arbiter dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_address       (req_address),
        .req_byteenable    (req_byteenable),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_writedata     (req_writedata),
        .req_waitrequest   (req_waitrequest),
        .req_readdata      (req_readdata),
        .req_readdatavalid (req_readdatavalid),
        .oor_error         (oor_error),
        .mem_address       (mem_address),
        .mem_byteenable    (mem_byteenable),
        .mem_chipselect    (mem_chipselect),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_clken         (mem_clken),
        .mem_readdata      (mem_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 ^ 32'(i);
    endfunction

    // Behavioural RAM: registered q, byte-enabled write, old data on read-during-write.
    logic [31:0] ram [0:32767];
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            mem_readdata <= ram[mem_address];
            if (mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
        end
    end

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [14:0] a0;
        logic [14:0] a1;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [1:0]  wt_exp;
        logic        cs_exp;
        logic        we_exp;
        logic        oor_exp;
        logic [1:0]  rdv_exp;
        logic [31:0] rdata_exp;
    } vec_t;

    vec_t tbl [0:10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of requests at the falling edge; outputs settle before the next rise.
    task automatic drive(input logic [1:0] rd, input logic [1:0] wr, input logic [14:0] a0,
                         input logic [14:0] a1, input logic [3:0] be, input logic [31:0] wd);
        @(negedge clk);
        req_read       = rd;
        req_write      = wr;
        req_address    = {a1, a0};
        req_byteenable = {be, be};
        req_writedata  = {wd, wd};
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        req_read  = '0;
        req_write = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    int exp_g [0:9];
    int fair_g [0:7];

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = init_val(i);
        mem_readdata   = '0;
        reset_n        = 1'b0;
        req_read       = '0;
        req_write      = '0;
        req_address    = '0;
        req_byteenable = '0;
        req_writedata  = '0;

        tbl[0]  = '{2'b00, 2'b01, 15'h0010, 15'h0000, 4'hF, 32'hA5A5_1234, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0};
        tbl[1]  = '{2'b01, 2'b00, 15'h0010, 15'h0000, 4'hF, 32'h0,         2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0};
        tbl[2]  = '{2'b00, 2'b00, 15'h0000, 15'h0000, 4'h0, 32'h0,         2'b11, 1'b0, 1'b0, 1'b0, 2'b01, 32'hA5A5_1234};
        tbl[3]  = '{2'b00, 2'b01, 15'h0020, 15'h0000, 4'hF, 32'hFFFF_FFFF, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0};
        tbl[4]  = '{2'b00, 2'b01, 15'h0020, 15'h0000, 4'h5, 32'h0000_0000, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0};
        tbl[5]  = '{2'b01, 2'b00, 15'h0020, 15'h0000, 4'hF, 32'h0,         2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0};
        tbl[6]  = '{2'b00, 2'b00, 15'h0000, 15'h0000, 4'h0, 32'h0,         2'b11, 1'b0, 1'b0, 1'b0, 2'b01, 32'hFF00_FF00};
        tbl[7]  = '{2'b10, 2'b00, 15'h0000, 15'h6400, 4'hF, 32'h0,         2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0};
        tbl[8]  = '{2'b00, 2'b10, 15'h0000, 15'h7FFF, 4'hF, 32'hDEAD_BEEF, 2'b01, 1'b0, 1'b1, 1'b1, 2'b10, 32'h0};
        tbl[9]  = '{2'b10, 2'b00, 15'h0000, 15'h3FFF, 4'hF, 32'h0,         2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0};
        tbl[10] = '{2'b00, 2'b00, 15'h0000, 15'h0000, 4'h0, 32'h0,         2'b11, 1'b0, 1'b0, 1'b0, 2'b10, 32'hC0DE_3FFF};

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rdv",   32'(req_readdatavalid), 32'h0);
        chk("reset_oor",   32'(oor_error),         32'h0);
        chk("reset_rdata", req_readdata,           32'h0);
        chk("reset_wait",  32'(req_waitrequest),   32'h3);
        chk("clken",       32'(mem_clken),         32'h1);
        @(negedge clk);
        reset_n = 1'b1;

        // Single-requester data path, byte enables and out-of-range accesses
        for (int i = 0; i <= 10; i++) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].a0, tbl[i].a1, tbl[i].be, tbl[i].wd);
            chk($sformatf("v%0d_wait", i), 32'(req_waitrequest),   32'(tbl[i].wt_exp));
            chk($sformatf("v%0d_cs", i),   32'(mem_chipselect),    32'(tbl[i].cs_exp));
            chk($sformatf("v%0d_we", i),   32'(mem_write),         32'(tbl[i].we_exp));
            chk($sformatf("v%0d_oor", i),  32'(oor_error),         32'(tbl[i].oor_exp));
            chk($sformatf("v%0d_rdv", i),  32'(req_readdatavalid), 32'(tbl[i].rdv_exp));
            if (tbl[i].rdv_exp != 2'b00)
                chk($sformatf("v%0d_rdata", i), req_readdata, tbl[i].rdata_exp);
        end

        // Contention: both read continuously from reset
        exp_g = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(2'b11, 2'b00, 15'h0100, 15'h0200, 4'hF, 32'h0);
            chk($sformatf("cont%0d_wait", k), 32'(req_waitrequest), (exp_g[k] == 0) ? 32'h2 : 32'h1);
            if (k > 0) begin
                chk($sformatf("cont%0d_rdv", k), 32'(req_readdatavalid), 32'h1 << exp_g[k-1]);
                chk($sformatf("cont%0d_rdata", k), req_readdata,
                    (exp_g[k-1] == 0) ? init_val(32'h100) : init_val(32'h200));
            end
        end

        // Fairness: requester 1 alone for two cycles, then requester 0 joins
        fair_g = '{1, 1, 1, 1, 0, 0, 0, 0};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive((k < 2) ? 2'b10 : 2'b11, 2'b00, 15'h0100, 15'h0200, 4'hF, 32'h0);
            chk($sformatf("fair%0d_wait", k), 32'(req_waitrequest), (fair_g[k] == 0) ? 32'h2 : 32'h1);
        end

        // Reset while a read return is pending
        do_reset();
        drive(2'b10, 2'b00, 15'h0100, 15'h0200, 4'hF, 32'h0);
        chk("mid_accept", 32'(req_waitrequest), 32'h1);
        @(posedge clk);
        #1;
        chk("mid_pending", 32'(req_readdatavalid), 32'h2);
        @(negedge clk);
        reset_n   = 1'b0;
        req_read  = '0;
        #1;
        chk("mid_rst_rdv", 32'(req_readdatavalid), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drive(2'b00, 2'b00, 15'h0, 15'h0, 4'h0, 32'h0);
        chk("mid_rel_rdv", 32'(req_readdatavalid), 32'h0);
        drive(2'b11, 2'b00, 15'h0100, 15'h0200, 4'hF, 32'h0);
        chk("mid_first_grant", 32'(req_waitrequest), 32'h2);
        chk("mid_rdv_idle",    32'(req_readdatavalid), 32'h0);
        drive(2'b00, 2'b00, 15'h0, 15'h0, 4'h0, 32'h0);
        chk("mid_rdv_after", 32'(req_readdatavalid), 32'h1);
        chk("mid_rdata",     req_readdata, init_val(32'h100));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/comm_mem_arbiter.md
Name: comm_mem_arbiter

Overview:
- Shares the single-port communication on-chip memory (32-bit data, 15-bit word address, 25600 words, byte enables, 1-cycle read latency) between NUM_REQ Avalon-MM style requesters.
- Typical requesters: Nios data master and the Car2X packet DMA.
- Performs round-robin arbitration with a bounded hold (burst) window and routes read data back to the issuing requester.
- Blocks out-of-range accesses.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 15, word address width.
- DEPTH, 25600, number of valid words; addresses >= DEPTH are out of range.
- MAX_HOLD, 4, maximum consecutive accesses granted to one requester while another is waiting.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_address  in  NUM_REQ*ADDR_W  per-requester word address; requester i occupies slice i.
- req_byteenable  in  NUM_REQ*4  per-requester byte enables.
- req_read  in  NUM_REQ  read request.
- req_write  in  NUM_REQ  write request.
- req_writedata  in  NUM_REQ*32  write data.
- req_waitrequest  out  NUM_REQ  1 = not accepted this cycle.
- req_readdata  out  32  shared read-data bus, qualified by req_readdatavalid.
- req_readdatavalid  out  NUM_REQ  one-hot read-return strobe.
- oor_error  out  1  one-cycle pulse when an out-of-range access is accepted.
- mem_address  out  ADDR_W  to RAM.
- mem_byteenable  out  4  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  32  to RAM.
- mem_clken  out  1  RAM clock enable; constant 1.
- mem_readdata  in  32  RAM output (unregistered q).

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is asynchronous, active-low, on reset_n.
- Values while reset_n = 0:
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - hold_cnt = 0.
  - rd_pending = 0; rd_owner = 0; rd_oor = 0.
  - req_readdatavalid = 0; oor_error = 0; req_readdata = 0.
- Request and grant:
  - Request i is active when req_read[i] | req_write[i].
  - The grant is combinational from active requests, last_grant and hold_cnt.
  - Only one access is issued per cycle; the arbiter never idles while any request is active.
- Grant selection:
  - If requester last_grant is active and (hold_cnt < MAX_HOLD-1, or no other request is active), it keeps the grant.
  - Otherwise the first active requester scanning last_grant+1, +2, … (mod NUM_REQ) wins.
- Acceptance:
  - Granted requester: req_waitrequest = 0 in the same cycle and the access is issued.
  - All other requesters: req_waitrequest = 1.
  - Inactive requesters: req_waitrequest = 1, which is don't-care for Avalon.
- Hold counter, updated on each accepted access:
  - Same requester as last_grant: hold_cnt increments, saturating at MAX_HOLD-1.
  - Different requester: hold_cnt = 0 and last_grant = winner.
  - No access this cycle: hold_cnt = 0, last_grant unchanged.
- Memory drive for an issued access:
  - mem_address, mem_byteenable and mem_writedata come from the winner's slice.
  - mem_chipselect = 1 unless out of range.
  - mem_write = req_write of the winner.
  - With no access, mem_chipselect = 0 and mem_write = 0.
- Write plus read from the same requester in one cycle: the write is performed and the read is dropped (no readdatavalid). Simulation assertion flags it.
- Read latency: fixed 1.
  - A read accepted in cycle N sets rd_pending and records rd_owner.
  - In cycle N+1: req_readdatavalid[rd_owner] = 1 and req_readdata = mem_readdata, or 0 if the read was out of range.
  - Back-to-back reads from any mix of requesters sustain 1 read per cycle.
- Out of range (address >= DEPTH):
  - The access is accepted: waitrequest = 0, no stall.
  - mem_chipselect = 0, so the RAM is not accessed.
  - A read returns 32'h0 with normal valid timing.
  - oor_error pulses in the accept cycle.
- Write response: none. A write is complete on acceptance.
- Reset asserted mid-read: the pending readdatavalid is discarded and never emitted after reset release.
- mem_clken is tied to 1; the block contains no stall path into the RAM.

Decomposition:
- Package comm_mem_pkg holds:
  - constants COMM_MEM_DEPTH = 25600, COMM_MEM_ADDR_W = 15, COMM_MEM_DATA_W = 32, COMM_MEM_BE_W = 4;
  - function next_rr(req_vec, last) returning the winner index.
- One sub-module, comm_mem_rr_sel: combinational round-robin/hold selector. Inputs: active vector, last_grant, hold_cnt. Outputs: winner index and any_grant.
- Top level holds the state registers, address/data muxes, range check and read-return pipeline.

Test Plan:
- Single requester 0: write 0xA5A5_1234 to addr 0x0010 with byteenable 4'hF, then read 0x0010 → waitrequest 0 both cycles; readdatavalid[0] one cycle after the read with readdata 0xA5A5_1234.
- Byte enable: write 0xFFFF_FFFF, then write 0x0000_0000 with byteenable 4'b0101, then read → 0xFF00_FF00.
- Contention: both requesters hold reads continuously from reset, MAX_HOLD = 4 → grant sequence 0,0,0,0,1,1,1,1,0… Each readdatavalid arrives on the correct requester with the correct data.
- Fairness: requester 1 requests alone for 2 cycles, then requester 0 joins → requester 1 keeps the grant until 4 consecutive accepts total, then requester 0 is granted the next cycle.
- Out of range: read at addr 25600 (0x6400) → mem_chipselect 0, oor_error pulse, readdatavalid next cycle with readdata 0x0. A write to 0x7FFF leaves addr 0x7FFF & 0x3FFF unchanged on readback.
- Reset mid-operation: read accepted, then reset_n low in the next half-cycle → no readdatavalid after release; first grant after release goes to requester 0.
